// File: rtl/edge_detection_ori.sv
`default_nettype none
// =============================================================================
// edge_detection_ori : two-layer 3x3 engine (blur -> L1, Sobel+threshold -> L2)
// Optional median blur compiled in with EDGE_MEDIAN_EN.      Revision: 1.0
// =============================================================================
module edge_detection_ori (
    input  logic        clk,
    input  logic        reset,
    output logic        busy,
    input  logic        switch,
    input  logic [7:0]  threshold,
    output logic [11:0] iaddr_1, iaddr_2, iaddr_3, iaddr_4, iaddr_5,
    output logic [11:0] iaddr_6, iaddr_7, iaddr_8, iaddr_9,
    input  logic [7:0]  idata_1, idata_2, idata_3, idata_4, idata_5,
    input  logic [7:0]  idata_6, idata_7, idata_8, idata_9,
    output logic        crd,
    output logic [11:0] caddr_rd_1, caddr_rd_2, caddr_rd_3, caddr_rd_4, caddr_rd_5,
    output logic [11:0] caddr_rd_6, caddr_rd_7, caddr_rd_8, caddr_rd_9,
    input  logic [7:0]  cdata_rd_1, cdata_rd_2, cdata_rd_3, cdata_rd_4, cdata_rd_5,
    input  logic [7:0]  cdata_rd_6, cdata_rd_7, cdata_rd_8, cdata_rd_9,
    output logic        cwr,
    output logic [11:0] caddr_wr,
    output logic [7:0]  cdata_wr,
    output logic [2:0]  csel
);

    localparam logic [2:0]  S_IDLE   = 3'd0;
    localparam logic [2:0]  S_L1_RD  = 3'd1;
    localparam logic [2:0]  S_L1_WR  = 3'd2;
    localparam logic [2:0]  S_L2_RD  = 3'd3;
    localparam logic [2:0]  S_L2_WR  = 3'd4;
    localparam logic [2:0]  S_DONE   = 3'd5;
    localparam logic [11:0] LAST_PIX = 12'd4095;

    logic [2:0]  state_q, state_d;
    logic [11:0] pix_q, pix_d;
    logic [11:0] win_q [9];
    logic [11:0] win_d [9];
    logic [8:0]  mask_q, mask_d;
    logic        busy_q, busy_d, crd_q, crd_d, cwr_q, cwr_d;
    logic [2:0]  csel_q, csel_d;
    logic [11:0] caddr_wr_q, caddr_wr_d;
    logic [7:0]  cdata_wr_q, cdata_wr_d;
    logic [7:0]  thr_q, thr_d;

    logic [11:0] tgt;
    logic [11:0] win_n [9];
    logic [8:0]  mask_n;
    logic [6:0]  nr, nc;
    logic [7:0]  idata_a [9];
    logic [7:0]  cdata_a [9];
    logic [7:0]  src_px [9];
    logic [7:0]  l1_px [9];
    logic [11:0] gsum;
    logic [7:0]  blur, bin;
    logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg, gx, gy, gx_abs, gy_abs, mag;

    always_comb begin
        idata_a = '{idata_1, idata_2, idata_3, idata_4, idata_5, idata_6, idata_7, idata_8, idata_9};
        cdata_a = '{cdata_rd_1, cdata_rd_2, cdata_rd_3, cdata_rd_4, cdata_rd_5,
                    cdata_rd_6, cdata_rd_7, cdata_rd_8, cdata_rd_9};
    end

    // Window of the pixel about to be read; off-image taps fall back to the centre.
    always_comb begin
        tgt    = (state_q == S_IDLE) ? pix_q : pix_q + 12'd1;
        nr     = '0;
        nc     = '0;
        mask_n = '0;
        for (int k = 0; k < 9; k++) begin
            nr        = {1'b0, tgt[11:6]} + 7'(k / 3) - 7'd1;
            nc        = {1'b0, tgt[5:0]} + 7'(k % 3) - 7'd1;
            mask_n[k] = ~nr[6] & ~nc[6];
            win_n[k]  = mask_n[k] ? {nr[5:0], nc[5:0]} : tgt;
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            src_px[k] = mask_q[k] ? idata_a[k] : 8'd0;
            l1_px[k]  = mask_q[k] ? cdata_a[k] : 8'd0;
        end
    end

    always_comb begin
        gsum = {4'd0, src_px[0]} + {3'd0, src_px[1], 1'b0} + {4'd0, src_px[2]}
             + {3'd0, src_px[3], 1'b0} + {2'd0, src_px[4], 2'b0} + {3'd0, src_px[5], 1'b0}
             + {4'd0, src_px[6]} + {3'd0, src_px[7], 1'b0} + {4'd0, src_px[8]};
    end

`ifdef EDGE_MEDIAN_EN
    logic       sw_q, sw_d;
    logic [7:0] med;
    logic [3:0] rank;

    // Stable rank of each tap; the one ranked 4 is the 5th smallest.
    always_comb begin
        med  = '0;
        rank = '0;
        for (int i = 0; i < 9; i++) begin
            rank = '0;
            for (int j = 0; j < 9; j++) begin
                if (src_px[j] < src_px[i] || (src_px[j] == src_px[i] && j < i))
                    rank = rank + 4'd1;
            end
            if (rank == 4'd4)
                med = src_px[i];
        end
    end

    always_comb sw_d = (state_q == S_IDLE) ? switch : sw_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sw_q <= 1'b0;
        else       sw_q <= sw_d;
    end

    assign blur = sw_q ? gsum[11:4] : med;
`else
    logic switch_unused;
    assign switch_unused = switch;
    assign blur          = gsum[11:4];
`endif

    // Two's-complement gradients; |G| <= 1020 so 11 bits never wrap.
    always_comb begin
        gx_pos = {3'd0, l1_px[2]} + {2'd0, l1_px[5], 1'b0} + {3'd0, l1_px[8]};
        gx_neg = {3'd0, l1_px[0]} + {2'd0, l1_px[3], 1'b0} + {3'd0, l1_px[6]};
        gy_pos = {3'd0, l1_px[6]} + {2'd0, l1_px[7], 1'b0} + {3'd0, l1_px[8]};
        gy_neg = {3'd0, l1_px[0]} + {2'd0, l1_px[1], 1'b0} + {3'd0, l1_px[2]};
        gx     = gx_pos - gx_neg;
        gy     = gy_pos - gy_neg;
        gx_abs = gx[10] ? -gx : gx;
        gy_abs = gy[10] ? -gy : gy;
        mag    = gx_abs + gy_abs;
        bin    = (mag > {3'd0, thr_q}) ? 8'hFF : 8'h00;
    end

    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        win_d      = win_q;
        mask_d     = mask_q;
        busy_d     = busy_q;
        crd_d      = crd_q;
        cwr_d      = cwr_q;
        csel_d     = csel_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        thr_d      = thr_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_L1_RD;
                busy_d  = 1'b1;
                thr_d   = threshold;
                pix_d   = tgt;
                win_d   = win_n;
                mask_d  = mask_n;
            end
            S_L1_RD: begin
                state_d    = S_L1_WR;
                cwr_d      = 1'b1;
                csel_d     = 3'b001;
                caddr_wr_d = pix_q;
                cdata_wr_d = blur;
            end
            S_L1_WR: begin
                cwr_d  = 1'b0;
                csel_d = 3'b000;
                pix_d  = tgt;
                win_d  = win_n;
                mask_d = mask_n;
                if (pix_q == LAST_PIX) begin
                    state_d = S_L2_RD;
                    crd_d   = 1'b1;
                    csel_d  = 3'b001;
                end else begin
                    state_d = S_L1_RD;
                end
            end
            S_L2_RD: begin
                state_d    = S_L2_WR;
                crd_d      = 1'b0;
                cwr_d      = 1'b1;
                csel_d     = 3'b010;
                caddr_wr_d = pix_q;
                cdata_wr_d = bin;
            end
            S_L2_WR: begin
                cwr_d  = 1'b0;
                csel_d = 3'b000;
                if (pix_q == LAST_PIX) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_L2_RD;
                    crd_d   = 1'b1;
                    csel_d  = 3'b001;
                    pix_d   = tgt;
                    win_d   = win_n;
                    mask_d  = mask_n;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pix_q      <= '0;
            mask_q     <= '0;
            busy_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= 3'b000;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            thr_q      <= '0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            mask_q     <= mask_d;
            busy_q     <= busy_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            csel_q     <= csel_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            thr_q      <= thr_d;
            win_q      <= win_d;
        end
    end

    assign busy     = busy_q;
    assign crd      = crd_q;
    assign cwr      = cwr_q;
    assign csel     = csel_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;

    // One window register set serves both the source ROM and the L1 read port.
    assign iaddr_1 = win_q[0];  assign caddr_rd_1 = win_q[0];
    assign iaddr_2 = win_q[1];  assign caddr_rd_2 = win_q[1];
    assign iaddr_3 = win_q[2];  assign caddr_rd_3 = win_q[2];
    assign iaddr_4 = win_q[3];  assign caddr_rd_4 = win_q[3];
    assign iaddr_5 = win_q[4];  assign caddr_rd_5 = win_q[4];
    assign iaddr_6 = win_q[5];  assign caddr_rd_6 = win_q[5];
    assign iaddr_7 = win_q[6];  assign caddr_rd_7 = win_q[6];
    assign iaddr_8 = win_q[7];  assign caddr_rd_8 = win_q[7];
    assign iaddr_9 = win_q[8];  assign caddr_rd_9 = win_q[8];

endmodule
`default_nettype wire

// File: tb/tb_edge_detection_ori.sv
`default_nettype none
// =============================================================================
// tb_edge_detection_ori : scoreboard bench for edge_detection_ori
// Revision: 1.0
// =============================================================================
module tb_edge_detection_ori;

    typedef struct {
        logic [2:0]  sel;
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        switch = 1'b1;
    logic [7:0]  threshold = 8'd56;
    logic        busy, crd, cwr;
    logic [2:0]  csel;
    logic [11:0] caddr_wr;
    logic [7:0]  cdata_wr;
    logic [11:0] iaddr [9];
    logic [7:0]  idata [9];
    logic [11:0] caddr_rd [9];
    logic [7:0]  cdata_rd [9];

    logic [7:0]  img [4096];
    logic [7:0]  l1_mem [4096];
    logic [7:0]  l2_mem [4096];
    logic [7:0]  exp_l1 [4096];
    logic [7:0]  exp_l2 [4096];
    logic [7:0]  snap_l1 [4096];

    wr_t sb_q [$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  bc;
    int  diffs;

    edge_detection_ori dut (
        .clk(clk), .reset(reset), .busy(busy), .switch(switch), .threshold(threshold),
        .iaddr_1(iaddr[0]), .iaddr_2(iaddr[1]), .iaddr_3(iaddr[2]), .iaddr_4(iaddr[3]),
        .iaddr_5(iaddr[4]), .iaddr_6(iaddr[5]), .iaddr_7(iaddr[6]), .iaddr_8(iaddr[7]),
        .iaddr_9(iaddr[8]),
        .idata_1(idata[0]), .idata_2(idata[1]), .idata_3(idata[2]), .idata_4(idata[3]),
        .idata_5(idata[4]), .idata_6(idata[5]), .idata_7(idata[6]), .idata_8(idata[7]),
        .idata_9(idata[8]),
        .crd(crd),
        .caddr_rd_1(caddr_rd[0]), .caddr_rd_2(caddr_rd[1]), .caddr_rd_3(caddr_rd[2]),
        .caddr_rd_4(caddr_rd[3]), .caddr_rd_5(caddr_rd[4]), .caddr_rd_6(caddr_rd[5]),
        .caddr_rd_7(caddr_rd[6]), .caddr_rd_8(caddr_rd[7]), .caddr_rd_9(caddr_rd[8]),
        .cdata_rd_1(cdata_rd[0]), .cdata_rd_2(cdata_rd[1]), .cdata_rd_3(cdata_rd[2]),
        .cdata_rd_4(cdata_rd[3]), .cdata_rd_5(cdata_rd[4]), .cdata_rd_6(cdata_rd[5]),
        .cdata_rd_7(cdata_rd[6]), .cdata_rd_8(cdata_rd[7]), .cdata_rd_9(cdata_rd[8]),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
    );

    always #5 clk = ~clk;

    // Source ROM and L1 read port: data follows the registered address.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            idata[k]    = img[iaddr[k]];
            cdata_rd[k] = l1_mem[caddr_rd[k]];
        end
    end

    // Result RAMs; filled with 5A while reset so missing writes show up.
    always @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 4096; p++) begin
                l1_mem[p] <= 8'h5A;
                l2_mem[p] <= 8'h5A;
            end
        end else if (cwr) begin
            if (csel == 3'b001) l1_mem[caddr_wr] <= cdata_wr;
            else if (csel == 3'b010) l2_mem[caddr_wr] <= cdata_wr;
        end
    end

    always @(negedge clk) begin
        if (!reset && (cwr || crd)) begin
            checks++;
            if ((cwr && crd) || (crd && csel != 3'b001)) begin
                errors++;
                $display("FAIL rd_strobe: cwr=%0b crd=%0b csel=%03b, required one strobe and csel 001 on read",
                         cwr, crd, csel);
            end
            if (cwr) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: csel=%03b addr=%0d data=%02h, required no write",
                             csel, caddr_wr, cdata_wr);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({csel, caddr_wr, cdata_wr} !== {mon_e.sel, mon_e.addr, mon_e.data}) begin
                        errors++;
                        $display("FAIL write: got csel=%03b addr=%0d data=%02h, required csel=%03b addr=%0d data=%02h",
                                 csel, caddr_wr, cdata_wr, mon_e.sel, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        int aor;
        aor = 0;
        for (int k = 0; k < 9; k++) aor = aor | int'(iaddr[k]) | int'(caddr_rd[k]);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_strobes"}, int'({crd, cwr, csel}), 0);
        chk({tag, "_wr_bus"}, int'({caddr_wr, cdata_wr}), 0);
        chk({tag, "_addrs"}, aor, 0);
    endtask

    function automatic int px(input bit from_l1, input int r, input int c);
        if (r < 0 || r > 63 || c < 0 || c > 63) return 0;
        return from_l1 ? int'(exp_l1[r*64+c]) : int'(img[r*64+c]);
    endfunction

    task automatic build_model(input bit use_med, input logic [7:0] th);
        int v [9];
        int t, gx, gy, mag;
        for (int p = 0; p < 4096; p++) begin
            for (int k = 0; k < 9; k++) v[k] = px(1'b0, p/64 + k/3 - 1, p%64 + k%3 - 1);
            if (use_med) begin
                for (int i = 0; i < 8; i++)
                    for (int j = 0; j < 8 - i; j++)
                        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
                exp_l1[p] = 8'(v[4]);
            end else begin
                exp_l1[p] = 8'((v[0] + 2*v[1] + v[2] + 2*v[3] + 4*v[4] + 2*v[5]
                               + v[6] + 2*v[7] + v[8]) / 16);
            end
        end
        for (int p = 0; p < 4096; p++) begin
            for (int k = 0; k < 9; k++) v[k] = px(1'b1, p/64 + k/3 - 1, p%64 + k%3 - 1);
            gx  = (v[2] + 2*v[5] + v[8]) - (v[0] + 2*v[3] + v[6]);
            gy  = (v[6] + 2*v[7] + v[8]) - (v[0] + 2*v[1] + v[2]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            exp_l2[p] = (mag > int'(th)) ? 8'hFF : 8'h00;
        end
        sb_q.delete();
        for (int p = 0; p < 4096; p++) sb_q.push_back('{3'b001, 12'(p), exp_l1[p]});
        for (int p = 0; p < 4096; p++) sb_q.push_back('{3'b010, 12'(p), exp_l2[p]});
    endtask

    // abort_cyc > 0 asserts reset mid-run (inside Layer 2) instead of completing.
    task automatic run_image(input logic sw, input logic [7:0] th, input int abort_cyc, output int cyc);
        bit use_med;
`ifdef EDGE_MEDIAN_EN
        use_med = (sw == 1'b0);
`else
        use_med = 1'b0;
`endif
        build_model(use_med, th);
        switch    = sw;
        threshold = th;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_outs("reset");
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        while (!busy && cyc < 4) begin @(posedge clk); #1; cyc++; end
        chk("busy_rise_cycle", cyc, 1);
        switch    = ~sw;
        threshold = ~th;
        if (abort_cyc > 0) begin
            repeat (abort_cyc) @(posedge clk);
            #3 reset = 1'b1;
            #1 chk_reset_outs("abort");
            snap_l1 = l1_mem;
            sb_q.delete();
        end else begin
            while (busy && cyc < 17000) begin @(posedge clk); #1; cyc++; end
            chk_range("busy_fall_cycle", cyc, 16384, 16388);
            chk("scoreboard_drained", sb_q.size(), 0);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single 160 at (10,10); first run aborted in Layer 2, then a full rerun.
        for (int p = 0; p < 4096; p++) img[p] = 8'd0;
        img[10*64+10] = 8'd160;
        run_image(1'b1, 8'd56, 10000, bc);
        run_image(1'b1, 8'd56, 0, bc);
        diffs = 0;
        for (int p = 0; p < 4096; p++) if (l1_mem[p] !== snap_l1[p]) diffs++;
        chk("rerun_l1_identical", diffs, 0);
        chk("dot_l1_centre", int'(l1_mem[10*64+10]), 40);
        chk("dot_l1_right", int'(l1_mem[10*64+11]), 20);
        chk("dot_l1_up", int'(l1_mem[9*64+10]), 20);
        chk("dot_l1_diag", int'(l1_mem[11*64+11]), 10);
        chk("dot_l1_far", int'(l1_mem[12*64+12]), 0);

        // All-zero image.
        for (int p = 0; p < 4096; p++) img[p] = 8'd0;
        run_image(1'b1, 8'd56, 0, bc);
        diffs = 0;
        for (int p = 0; p < 4096; p++) if (l1_mem[p] !== 8'd0 || l2_mem[p] !== 8'd0) diffs++;
        chk("zero_nonzero_entries", diffs, 0);

        // Constant 100, Gaussian; threshold flips after busy rises and must be ignored.
        for (int p = 0; p < 4096; p++) img[p] = 8'd100;
        run_image(1'b1, 8'd56, 0, bc);
        chk("c100_l1_interior", int'(l1_mem[32*64+32]), 100);
        chk("c100_l1_top_edge", int'(l1_mem[5]), 75);
        chk("c100_l1_left_edge", int'(l1_mem[10*64]), 75);
        chk("c100_l1_corner_tl", int'(l1_mem[0]), 56);
        chk("c100_l1_corner_br", int'(l1_mem[4095]), 56);
        chk("c100_l2_border", int'(l2_mem[5]), 255);
        chk("c100_l2_row1", int'(l2_mem[64+5]), 255);
        chk("c100_l2_interior", int'(l2_mem[32*64+32]), 0);

        // Vertical step, switch = 0.
        for (int p = 0; p < 4096; p++) img[p] = (p % 64 >= 32) ? 8'd200 : 8'd0;
        run_image(1'b0, 8'd56, 0, bc);
`ifdef EDGE_MEDIAN_EN
        chk("step_l1_c31", int'(l1_mem[10*64+31]), 0);
        chk("step_l1_c32", int'(l1_mem[10*64+32]), 200);
        chk("step_l2_c31", int'(l2_mem[10*64+31]), 255);
        chk("step_l2_c32", int'(l2_mem[10*64+32]), 255);
        chk("step_l2_c20", int'(l2_mem[10*64+20]), 0);
        chk("step_l2_c45", int'(l2_mem[10*64+45]), 0);
`else
        chk("step_gauss_l1_c31", int'(l1_mem[10*64+31]), 50);
        chk("step_gauss_l1_c32", int'(l1_mem[10*64+32]), 150);
        chk("step_gauss_l1_c20", int'(l1_mem[10*64+20]), 0);
        chk("step_gauss_l1_c45", int'(l1_mem[10*64+45]), 200);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
